// File: rtl/ip_tx_arb.sv
// Round-robin arbiter that shares the IP transmit engine between ICMP (port 0) and UDP (port 1).
// Optional frame/abort counters are enabled by defining IP_TX_ARB_STATS_EN.
module ip_tx_arb #(
  parameter int          GAP_CYCLES = 12,
  parameter logic [19:0] TIMEOUT    = 20'hFFFFF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        r0_req,
  input  logic [7:0]  r0_type,
  input  logic [15:0] r0_len,
  input  logic [7:0]  r0_data,
  input  logic        r0_ready,
  output logic        r0_ack,
  output logic        r0_data_req,
  output logic        r0_end,
  input  logic        r1_req,
  input  logic [7:0]  r1_type,
  input  logic [15:0] r1_len,
  input  logic [7:0]  r1_data,
  input  logic        r1_ready,
  output logic        r1_ack,
  output logic        r1_data_req,
  output logic        r1_end,
  output logic        ip_tx_req,
  input  logic        ip_tx_ack,
  output logic [7:0]  ip_send_type,
  output logic [15:0] ip_send_data_length,
  output logic [7:0]  upper_layer_data,
  output logic        upper_tx_ready,
  input  logic        upper_data_req,
  input  logic        ip_tx_end,
  output logic        grant,
  output logic        busy,
  output logic [1:0]  dbg_state
`ifdef IP_TX_ARB_STATS_EN
  ,
  output logic [15:0] cnt0,
  output logic [15:0] cnt1,
  output logic [15:0] cnt_abort
`endif
);

  // Handshake: a requester holds rX_req until rX_ack; the engine sees ip_tx_req
  // from GRANT entry until it answers with a one-cycle ip_tx_ack, and closes the
  // frame with a one-cycle ip_tx_end.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam int            GW       = $clog2(GAP_CYCLES + 2);
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t        state_q, state_d;
  logic          grant_q, grant_d;
  logic          last_q, last_d;
  logic          req_q, req_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic [19:0]   tcnt_q, tcnt_d;
  logic          tmo;

  assign tmo = (tcnt_q == TIMEOUT - 20'd1);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    req_d   = req_q;
    gcnt_d  = gcnt_q;
    tcnt_d  = tcnt_q;
    case (state_q)
      IDLE: begin
        if (r0_req || r1_req) begin
          // With both asking, the one not served last wins.
          grant_d = (r0_req && r1_req) ? ~last_q : r1_req;
          last_d  = grant_d;
          tcnt_d  = '0;
          req_d   = 1'b1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (tmo) begin
          req_d   = 1'b0;
          gcnt_d  = GAP_LOAD;
          state_d = GAP;
        end else begin
          tcnt_d = tcnt_q + 20'd1;
          if (ip_tx_ack) begin
            req_d   = 1'b0;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        // A frame end in the timeout cycle still counts as a normal end.
        if (ip_tx_end || tmo) begin
          gcnt_d  = GAP_LOAD;
          state_d = GAP;
        end else begin
          tcnt_d = tcnt_q + 20'd1;
        end
      end
      GAP: begin
        if (gcnt_q == '0) state_d = IDLE;
        else              gcnt_d  = gcnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      req_q   <= 1'b0;
      gcnt_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      req_q   <= req_d;
      gcnt_q  <= gcnt_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign busy      = (state_q == GRANT) || (state_q == BUSY);
  assign grant     = grant_q;
  assign dbg_state = state_q;
  assign ip_tx_req = req_q;

  assign ip_send_type        = !busy ? 8'd0  : (grant_q ? r1_type  : r0_type);
  assign ip_send_data_length = !busy ? 16'd0 : (grant_q ? r1_len   : r0_len);
  assign upper_layer_data    = !busy ? 8'd0  : (grant_q ? r1_data  : r0_data);
  assign upper_tx_ready      = busy && (grant_q ? r1_ready : r0_ready);

  assign r0_ack      = busy && !grant_q && ip_tx_ack;
  assign r0_data_req = busy && !grant_q && upper_data_req;
  assign r0_end      = busy && !grant_q && ip_tx_end;
  assign r1_ack      = busy &&  grant_q && ip_tx_ack;
  assign r1_data_req = busy &&  grant_q && upper_data_req;
  assign r1_end      = busy &&  grant_q && ip_tx_end;

`ifdef IP_TX_ARB_STATS_EN
  logic end_ok, abort;

  assign end_ok = (state_q == BUSY) && ip_tx_end;
  assign abort  = busy && tmo && !end_ok;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt0      <= '0;
      cnt1      <= '0;
      cnt_abort <= '0;
    end else begin
      if (end_ok && !grant_q) cnt0      <= cnt0 + 16'd1;
      if (end_ok &&  grant_q) cnt1      <= cnt1 + 16'd1;
      if (abort)              cnt_abort <= cnt_abort + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ip_tx_arb.sv
// Randomised frame-level bench for ip_tx_arb: the driver plans frames and pushes
// expectations, a negedge monitor pops them when the DUT starts a frame.
module tb_ip_tx_arb;
  localparam int GAP = 12;
  localparam int TMO = 100;
  localparam int K_NORM = 0, K_ABORT = 1, K_COIN = 2, K_RST = 3;

  logic        clk = 1'b0;
  logic        rstn;
  logic        r0_req, r0_ready, r1_req, r1_ready;
  logic [7:0]  r0_type, r0_data, r1_type, r1_data;
  logic [15:0] r0_len, r1_len;
  logic        r0_ack, r0_data_req, r0_end, r1_ack, r1_data_req, r1_end;
  logic        ip_tx_req, ip_tx_ack, upper_tx_ready, upper_data_req, ip_tx_end;
  logic [7:0]  ip_send_type, upper_layer_data;
  logic [15:0] ip_send_data_length;
  logic        grant, busy;
  logic [1:0]  dbg_state;
`ifdef IP_TX_ARB_STATS_EN
  logic [15:0] cnt0, cnt1, cnt_abort;
  logic [15:0] exp_c0 = '0, exp_c1 = '0, exp_ca = '0;
`endif

  always #5 clk = ~clk;

  ip_tx_arb #(.GAP_CYCLES(GAP), .TIMEOUT(20'd100)) dut (
    .clk(clk), .rstn(rstn),
    .r0_req(r0_req), .r0_type(r0_type), .r0_len(r0_len), .r0_data(r0_data), .r0_ready(r0_ready),
    .r0_ack(r0_ack), .r0_data_req(r0_data_req), .r0_end(r0_end),
    .r1_req(r1_req), .r1_type(r1_type), .r1_len(r1_len), .r1_data(r1_data), .r1_ready(r1_ready),
    .r1_ack(r1_ack), .r1_data_req(r1_data_req), .r1_end(r1_end),
    .ip_tx_req(ip_tx_req), .ip_tx_ack(ip_tx_ack), .ip_send_type(ip_send_type),
    .ip_send_data_length(ip_send_data_length), .upper_layer_data(upper_layer_data),
    .upper_tx_ready(upper_tx_ready), .upper_data_req(upper_data_req), .ip_tx_end(ip_tx_end),
    .grant(grant), .busy(busy), .dbg_state(dbg_state)
`ifdef IP_TX_ARB_STATS_EN
    , .cnt0(cnt0), .cnt1(cnt1), .cnt_abort(cnt_abort)
`endif
  );

  // Frame plan: request set, kind, ack offset, end (or reset) offset, fixed-payload flag.
  typedef struct {
    logic [1:0] s;
    int         kind;
    int         a;
    int         e;
    bit         fix;
  } frame_t;

  frame_t      frames[$];
  // Expectation word: [31:30] kind, [29] end pulse, [28] exact gap, [27] grant, [23:16] ack offset, [15:0] length.
  logic [31:0] exp_q[$];
  logic [31:0] cur;
  int          n_checks = 0, n_pass = 0;
  bit          model_last = 1'b1;
  bit          mon_en = 1'b0, in_frame = 1'b0, dead = 1'b0;
  int          mon_n, mon_low = 0, mon_ends;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic rand_fields();
    r0_type = 8'($urandom);
    r1_type = 8'($urandom);
    r0_len  = 16'($urandom_range(20, 1500));
    r1_len  = 16'($urandom_range(20, 1500));
  endtask

  task automatic step(input bit fix);
    @(posedge clk);
    #1;
    if (!fix) begin
      r0_data = 8'($urandom);
      r1_data = 8'($urandom);
    end
    r0_ready       = 1'($urandom_range(0, 1));
    r1_ready       = 1'($urandom_range(0, 1));
    upper_data_req = 1'($urandom_range(0, 1));
  endtask

  // Raise the request set for frame i and record what the arbiter must do with it.
  task automatic plan(input int i, input bit chk_gap);
    frame_t f;
    logic   w;
    int     len;
    bit     ends;
    f = frames[i];
    r0_req = f.s[0];
    r1_req = f.s[1];
    w = (f.s == 2'b11) ? ~model_last : f.s[1];
    model_last = w;
    case (f.kind)
      K_NORM:  begin len = f.e + 1; ends = 1'b1; end
      K_ABORT: begin len = TMO;     ends = 1'b0; end
      K_COIN:  begin len = TMO;     ends = 1'b1; end
      default: begin len = f.e + 1; ends = 1'b0; end
    endcase
    exp_q.push_back({2'(f.kind), ends, chk_gap, w, 3'b000, 8'(f.a), 16'(len)});
  endtask

  // Play the engine side of frame i; the next frame's requests go up while this one is busy.
  task automatic run_frame(input int i);
    frame_t f;
    int     waited;
    int     n;
    bit     has_next;
    f = frames[i];
    has_next = (i + 1 < frames.size());
    waited = 0;
    while (ip_tx_req !== 1'b1 && waited < 200) begin
      step(1'b0);
      ip_tx_ack = 1'b0;
      ip_tx_end = 1'b0;
      waited++;
    end
    if (ip_tx_req !== 1'b1) begin
      n_checks++;
      $display("FAIL req_wait: ip_tx_req=%b after %0d cycles, required 1", ip_tx_req, waited);
      dead = 1'b1;
      return;
    end
    if (f.fix) begin
      r1_len  = 16'd46;
      r1_data = 8'hA5;
    end
    n = 0;
    forever begin
      if (n > 0) step(f.fix);
      ip_tx_ack = (n == f.a);
      if (n == f.a + 1) begin
        if (has_next && f.kind != K_RST) plan(i + 1, 1'b1);
        else begin
          r0_req = 1'b0;
          r1_req = 1'b0;
        end
      end
      if (f.kind == K_NORM || f.kind == K_COIN) begin
        ip_tx_end = (n == f.e);
        if (n == f.e + 1) begin
          ip_tx_ack = 1'b1;  // stray ack during the gap
          rand_fields();
          break;
        end
      end else if (f.kind == K_ABORT) begin
        if (n == TMO) begin
          rand_fields();
          break;
        end
      end else begin
        rstn = !(n == f.e);
        if (n == f.e + 1) ip_tx_end = 1'b1;  // stray end right after reset
        if (n == f.e + 2) begin
          ip_tx_end  = 1'b0;
          model_last = 1'b1;
          rand_fields();
          if (has_next) plan(i + 1, 1'b0);
          break;
        end
      end
      n++;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (in_frame && !busy) begin
        chk("frame_len", 64'(mon_n), 64'(cur[15:0]));
        chk("end_pulses", 64'(mon_ends), 64'(cur[29]));
`ifdef IP_TX_ARB_STATS_EN
        case (int'(cur[31:30]))
          K_NORM, K_COIN: if (cur[27]) exp_c1 = exp_c1 + 16'd1; else exp_c0 = exp_c0 + 16'd1;
          K_ABORT:        exp_ca = exp_ca + 16'd1;
          default: begin exp_c0 = '0; exp_c1 = '0; exp_ca = '0; end
        endcase
        chk("cnt0", 64'(cnt0), 64'(exp_c0));
        chk("cnt1", 64'(cnt1), 64'(exp_c1));
        chk("cnt_abort", 64'(cnt_abort), 64'(exp_ca));
`endif
        in_frame = 1'b0;
        mon_low  = 0;
      end
      if (!in_frame && busy) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_frame: busy=1 grant=%b, required busy=0", grant);
        end else begin
          cur      = exp_q.pop_front();
          in_frame = 1'b1;
          mon_n    = 0;
          mon_ends = 0;
          chk("grant_choice", 64'(grant), 64'(cur[27]));
          if (cur[28]) chk("gap_len", 64'(mon_low), 64'(GAP + 1));
        end
      end
      if (in_frame) begin
        chk("frame_cycle",
            64'({busy, grant, ip_tx_req, r0_ack, r0_data_req, r0_end, r1_ack, r1_data_req, r1_end,
                 ip_send_type, ip_send_data_length, upper_layer_data, upper_tx_ready}),
            64'({1'b1, cur[27], 1'(mon_n <= int'(cur[23:16])),
                 ~cur[27] & ip_tx_ack, ~cur[27] & upper_data_req, ~cur[27] & ip_tx_end,
                 cur[27] & ip_tx_ack, cur[27] & upper_data_req, cur[27] & ip_tx_end,
                 cur[27] ? r1_type : r0_type, cur[27] ? r1_len : r0_len,
                 cur[27] ? r1_data : r0_data, cur[27] ? r1_ready : r0_ready}));
        if (r0_end || r1_end) mon_ends++;
        mon_n++;
      end else begin
        mon_low++;
        chk("idle_outputs",
            64'({busy, ip_tx_req, r0_ack, r0_data_req, r0_end, r1_ack, r1_data_req, r1_end,
                 ip_send_type, ip_send_data_length, upper_layer_data, upper_tx_ready}),
            64'(0));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, e;
    rstn = 1'b0;
    {r0_req, r1_req, ip_tx_ack, ip_tx_end, upper_data_req, r0_ready, r1_ready} = '0;
    r0_data = '0;
    r1_data = '0;
    rand_fields();

    // Both held from reset, then directed single-requester, timeout and reset frames.
    for (int k = 0; k < 4; k++) begin
      a = $urandom_range(1, 4);
      frames.push_back('{2'b11, K_NORM, a, a + $urandom_range(2, 60), 1'b0});
    end
    frames.push_back('{2'b01, K_NORM, 3, 83, 1'b0});
    frames.push_back('{2'b10, K_NORM, 2, 30, 1'b1});
    frames.push_back('{2'b01, K_ABORT, 2, 0, 1'b0});
    frames.push_back('{2'b01, K_COIN, 3, TMO - 1, 1'b0});
    frames.push_back('{2'b10, K_RST, 2, 9, 1'b0});
    frames.push_back('{2'b11, K_NORM, 1, 20, 1'b0});
    for (int k = 0; k < 16; k++) begin
      a = $urandom_range(1, 4);
      e = a + $urandom_range(2, 60);
      frames.push_back('{2'($urandom_range(1, 3)), ($urandom_range(0, 5) == 0) ? K_ABORT : K_NORM,
                         a, e, 1'b0});
    end
    frames.push_back('{2'b11, K_COIN, 4, TMO - 1, 1'b0});
    frames.push_back('{2'b10, K_NORM, 1, 10, 1'b0});

    @(posedge clk);
    #1;
    mon_en = 1'b1;
    repeat (2) step(1'b0);
    chk("reset_state", 64'({dbg_state, grant, busy, ip_tx_req}), 64'(0));
    rstn = 1'b1;
    step(1'b0);

    plan(0, 1'b0);
    for (int i = 0; i < frames.size(); i++) begin
      if (dead) break;
      run_frame(i);
    end
    repeat (20) step(1'b0);
    ip_tx_ack = 1'b0;
    repeat (2) step(1'b0);
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ip_tx_arb.md
Name: ip_tx_arb

Overview:
- Two-requester arbiter sharing the single IP transmit engine between ICMP (port 0) and UDP (port 1).
- Grants one requester per frame and holds the grant until the frame ends. Muxes that requester's header fields and payload into the engine, and routes the engine's handshakes back to the granted requester only.
- Sits between the ICMP/UDP transmit blocks and the IP transmit engine. Enforces an inter-frame gap and recovers from a stalled frame by timeout.

Parameters:
- GAP_CYCLES, 12, idle cycles forced after each frame end or abort before the next grant.
- TIMEOUT, 20'hFFFFF, max cycles in GRANT+BUSY without ip_tx_end before abort.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- r0_req  in  1  ICMP frame request, level, held until r0_ack
- r0_type  in  8  IP protocol field for ICMP
- r0_len  in  16  IP total length for ICMP frame
- r0_data  in  8  ICMP payload byte
- r0_ready  in  1  ICMP payload ready
- r0_ack  out  1  engine ack routed to ICMP
- r0_data_req  out  1  payload request routed to ICMP
- r0_end  out  1  frame-end pulse routed to ICMP
- r1_req, r1_type, r1_len, r1_data, r1_ready, r1_ack, r1_data_req, r1_end: same as r0_*, for UDP
- ip_tx_req  out  1  request to engine
- ip_tx_ack  in  1  engine ack
- ip_send_type  out  8  muxed protocol
- ip_send_data_length  out  16  muxed length
- upper_layer_data  out  8  muxed payload
- upper_tx_ready  out  1  muxed ready
- upper_data_req  in  1  engine payload request
- ip_tx_end  in  1  engine frame-end pulse
- grant  out  1  0=ICMP, 1=UDP; valid when busy=1
- busy  out  1  high in GRANT or BUSY

Behaviour:
- Reset (synchronous, active-low rstn; clock clk):
  - state=IDLE, grant=0, last=1, gap counter=0, timeout counter=0.
  - All outputs 0.
  - Reset mid-frame drops ip_tx_req immediately; no end pulse is generated.
- States: IDLE, GRANT, BUSY, GAP.
- IDLE:
  - If exactly one of r0_req/r1_req is high, grant it.
  - If both are high, grant ~last (round-robin).
  - On a grant: register grant, set last=grant, go to GRANT. Decision to GRANT takes 1 cycle.
- GRANT:
  - ip_tx_req=1 (registered, asserted on GRANT entry).
  - On ip_tx_ack=1: deassert ip_tx_req next cycle, go to BUSY.
- BUSY:
  - Wait for ip_tx_end=1, then go to GAP with gap counter loaded to GAP_CYCLES-1.
- GAP:
  - Decrement the gap counter; go to IDLE when it reaches 0.
  - Requests are ignored during GAP.
  - GAP_CYCLES=0 is legal and means one GAP cycle.
- Timeout:
  - Counter clears on entry to GRANT and counts each cycle in GRANT or BUSY.
  - At TIMEOUT go to GAP (abort) and drop ip_tx_req.
  - No rX_end is generated on abort.
  - ip_tx_end arriving in the same cycle as the timeout takes precedence: normal end.
- Muxing (combinational from the grant register, zero latency):
  - ip_send_type, ip_send_data_length, upper_layer_data and upper_tx_ready carry the granted requester's inputs while busy=1, and are 0 otherwise.
  - rX_ack=ip_tx_ack, rX_data_req=upper_data_req and rX_end=ip_tx_end only for X==grant while busy=1. Both X=0 and X=1 receive 0 otherwise.
- Grant stays stable from GRANT entry to GAP entry. A requester dropping rX_req after grant does not release it; the frame completes or times out.
- ip_tx_ack or ip_tx_end seen in IDLE or GAP is ignored.
- A requester that keeps rX_req high after its end is re-eligible only after GAP. Round-robin then alternates if both stay high.

Optional Feature:
- Macro IP_TX_ARB_STATS_EN.
- Defined: adds outputs cnt0 (16), cnt1 (16) and cnt_abort (16).
  - cnt0/cnt1 increment on a normal end for that grant.
  - cnt_abort increments on timeout abort.
  - All three wrap at FFFF->0 and reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- r0_req only; engine acks 3 cycles after ip_tx_req and pulses ip_tx_end 80 cycles later -> grant=0, ip_send_type=r0_type, r0_ack/r0_end pulse once, r1_* stay 0, busy low after exactly GAP_CYCLES cycles in GAP.
- r0_req and r1_req both high from reset and held -> grant sequence 0,1,0,1 over four frames, with ≥12 idle cycles between ip_tx_end and the next ip_tx_req.
- r1 granted, r1_len=16'd46, r1_data=8'hA5, upper_data_req pulsed -> ip_send_data_length=46, upper_layer_data=A5, r1_data_req pulses, r0_data_req=0.
- TIMEOUT=100, ack given but ip_tx_end never sent -> abort at cycle 100, ip_tx_req=0, no r0_end, next grant possible after GAP; with the macro, cnt_abort=1.
- rstn low for 1 cycle while in BUSY -> next cycle state=IDLE, all outputs 0, stray ip_tx_end afterwards is ignored.
- ip_tx_end and the timeout in the same cycle -> r_end pulses; with the macro, cnt0 increments and cnt_abort stays 0.
